// File: rtl/cdb_issue_arbiter_pkg.sv
// rtl/cdb_issue_arbiter_pkg.sv - shared CDB widths, execution-unit ids and broadcast packet type
package cdb_issue_arbiter_pkg;

  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  typedef enum logic [1:0] {
    INT   = 2'd0,
    MULT  = 2'd1,
    DIV   = 2'd2,
    LD_ST = 2'd3
  } exec_unit_e;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  branch;
    logic                  taken;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_issue_arbiter_rr_priority_pick.sv
// rtl/cdb_issue_arbiter_rr_priority_pick.sv - rotate-priority encoder: first set bit at or after i_start
module rr_priority_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic          found;
  logic [IW-1:0] sel;

  always_comb begin
    found    = 1'b0;
    sel      = '0;
    o_onehot = '0;
    o_idx    = '0;
    for (int k = 0; k < N; k++) begin
      sel = IW'((int'(i_start) + k) % N);
      if (!found && i_req[sel]) begin
        found         = 1'b1;
        o_onehot[sel] = 1'b1;
        o_idx         = sel;
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/cdb_issue_arbiter.sv
// rtl/cdb_issue_arbiter.sv - round-robin CDB arbiter with registered broadcast and flush squash
module cdb_issue_arbiter
  import cdb_issue_arbiter_pkg::*;
#(
  parameter int N_REQ  = int'(LD_ST) + 1,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_flush,
  input  logic [N_REQ-1:0]               i_req_valid,
  input  logic [N_REQ-1:0][TAG_W-1:0]    i_req_tag,
  input  logic [N_REQ-1:0][DATA_W-1:0]   i_req_data,
  input  logic [N_REQ-1:0]               i_req_branch,
  input  logic [N_REQ-1:0]               i_req_taken,
  output logic [N_REQ-1:0]               o_req_gnt,
  output logic                           o_cdb_valid,
  output logic [TAG_W-1:0]               o_cdb_tag,
  output logic [DATA_W-1:0]              o_cdb_data,
  output logic                           o_cdb_branch,
  output logic                           o_cdb_taken
);

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  cdb_pkt_t         cdb_q, cdb_d;
  logic [N_REQ-1:0] pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             grant_ok;
  logic             grant_any;

  rr_priority_pick #(.N(N_REQ)) u_pick (
    .i_req    (i_req_valid),
    .i_start  (rr_ptr_q),
    .o_onehot (pick_onehot),
    .o_idx    (pick_idx),
    .o_any    (pick_any)
  );

  // Reset and flush both suppress the grant combinationally so requesters never see a lost handshake.
  assign grant_ok  = i_rst_n & ~i_flush;
  assign grant_any = grant_ok & pick_any;
  assign o_req_gnt = grant_ok ? pick_onehot : '0;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    if (grant_any) begin
      rr_ptr_d     = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
      cdb_d.valid  = 1'b1;
      cdb_d.tag    = i_req_tag[pick_idx];
      cdb_d.data   = i_req_data[pick_idx];
      cdb_d.branch = i_req_branch[pick_idx];
      cdb_d.taken  = i_req_taken[pick_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign o_cdb_valid  = cdb_q.valid;
  assign o_cdb_tag    = cdb_q.tag;
  assign o_cdb_data   = cdb_q.data;
  assign o_cdb_branch = cdb_q.branch;
  assign o_cdb_taken  = cdb_q.taken;

endmodule

// File: tb/tb_cdb_issue_arbiter.sv
// tb/tb_cdb_issue_arbiter.sv - directed and randomized-requester checks for cdb_issue_arbiter
module tb_cdb_issue_arbiter;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][5:0]  req_tag;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_branch;
  logic [3:0]       req_taken;
  logic [3:0]       gnt;
  logic             cdb_valid;
  logic [5:0]       cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_branch;
  logic             cdb_taken;

  int checks   = 0;
  int failures = 0;

  cdb_issue_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_req_valid  (req_valid),
    .i_req_tag    (req_tag),
    .i_req_data   (req_data),
    .i_req_branch (req_branch),
    .i_req_taken  (req_taken),
    .o_req_gnt    (gnt),
    .o_cdb_valid  (cdb_valid),
    .o_cdb_tag    (cdb_tag),
    .o_cdb_data   (cdb_data),
    .o_cdb_branch (cdb_branch),
    .o_cdb_taken  (cdb_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] pend;
  int         age [4];
  logic [3:0] granted;
  logic [5:0] exp_tag;

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    req_valid  = 4'hF;
    req_tag    = '0;
    req_data   = '0;
    req_branch = '0;
    req_taken  = '0;
    for (int i = 0; i < 4; i++) begin
      req_tag[i]  = 6'(i + 1);
      req_data[i] = 32'(16 * (i + 1));
    end

    // Reset held with every unit requesting
    repeat (3) begin
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
    end
    chk("rst_valid", 32'(cdb_valid), 32'h0);
    chk("rst_tag", 32'(cdb_tag), 32'h0);
    chk("rst_data", cdb_data, 32'h0);
    chk("rst_branch", 32'(cdb_branch), 32'h0);
    chk("rst_taken", 32'(cdb_taken), 32'h0);

    // Rotation with all four units requesting continuously
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rot_gnt", 32'(gnt), 32'(1 << (k % 4)));
      tick();
      chk("rot_valid", 32'(cdb_valid), 32'h1);
      chk("rot_tag", 32'(cdb_tag), 32'((k % 4) + 1));
    end

    // rr_ptr=1 now; grant unit 2 alone to move rr_ptr to 3
    req_valid = 4'b0100;
    #1;
    chk("to3_gnt", 32'(gnt), 32'b0100);
    tick();

    // Pointer skip and wrap: units 1 and 3 with rr_ptr=3
    req_valid = 4'b1010;
    #1;
    chk("wrap_gnt3", 32'(gnt), 32'b1000);
    tick();
    chk("wrap_tag4", 32'(cdb_tag), 32'd4);
    req_valid = 4'b0010;
    #1;
    chk("wrap_gnt1", 32'(gnt), 32'b0010);
    tick();
    chk("wrap_tag2", 32'(cdb_tag), 32'd2);
    req_valid = 4'b1111;
    #1;
    chk("ptr2_gnt", 32'(gnt), 32'b0100);
    tick();

    // Flush collision; request held through the flush is granted afterwards
    req_valid  = 4'b0100;
    req_tag[2] = 6'd9;
    flush      = 1'b1;
    #1;
    chk("flush_gnt", 32'(gnt), 32'h0);
    tick();
    chk("flush_valid", 32'(cdb_valid), 32'h0);
    flush = 1'b0;
    #1;
    chk("postflush_gnt", 32'(gnt), 32'b0100);
    tick();
    chk("postflush_valid", 32'(cdb_valid), 32'h1);
    chk("postflush_tag", 32'(cdb_tag), 32'd9);

    // Branch payload
    req_valid     = 4'b0001;
    req_tag[0]    = 6'd5;
    req_data[0]   = 32'h0000_0040;
    req_branch[0] = 1'b1;
    req_taken[0]  = 1'b1;
    #1;
    chk("br_gnt", 32'(gnt), 32'b0001);
    tick();
    chk("br_valid", 32'(cdb_valid), 32'h1);
    chk("br_tag", 32'(cdb_tag), 32'd5);
    chk("br_data", cdb_data, 32'h40);
    chk("br_branch", 32'(cdb_branch), 32'h1);
    chk("br_taken", 32'(cdb_taken), 32'h1);

    // Idle: valid drops, payload holds
    req_valid = 4'b0000;
    #1;
    chk("idle_gnt", 32'(gnt), 32'h0);
    tick();
    chk("idle_valid", 32'(cdb_valid), 32'h0);
    chk("idle_tag_hold", 32'(cdb_tag), 32'd5);
    chk("idle_data_hold", cdb_data, 32'h40);

    // Reset mid-stream
    req_valid = 4'b1111;
    rst_n     = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'h0);
    tick();
    chk("midrst_valid", 32'(cdb_valid), 32'h0);
    chk("midrst_tag", 32'(cdb_tag), 32'h0);
    chk("midrst_branch", 32'(cdb_branch), 32'h0);
    rst_n = 1'b1;

    // Random held requests: bounded wait, one-hot grant, tag tracking
    req_branch = '0;
    req_taken  = '0;
    pend       = '0;
    for (int i = 0; i < 4; i++) age[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i]     = 1'b1;
          age[i]      = 0;
          req_tag[i]  = 6'($urandom);
          req_data[i] = $urandom;
        end
      end
      req_valid = pend;
      #1;
      granted = gnt;
      chk("rand_onehot", 32'($onehot0(granted)), 32'h1);
      chk("rand_gnt_subset", 32'(granted & ~pend), 32'h0);
      chk("rand_gnt_any", 32'(granted != 4'b0), 32'(pend != 4'b0));
      exp_tag = '0;
      for (int i = 0; i < 4; i++) begin
        if (granted[i]) begin
          chk("rand_starve", 32'(age[i] < 4), 32'h1);
          exp_tag = req_tag[i];
        end
      end
      tick();
      chk("rand_valid", 32'(cdb_valid), 32'(granted != 4'b0));
      if (granted != 4'b0) chk("rand_tag", 32'(cdb_tag), 32'(exp_tag));
      for (int i = 0; i < 4; i++) begin
        if (granted[i]) pend[i] = 1'b0;
        else if (pend[i]) age[i] = age[i] + 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_issue_arbiter.md
# cdb_issue_arbiter

Round-robin arbiter that shares the single common data bus (CDB) between the execution units: integer, multiply, divide and load/store. Each cycle it grants at most one requesting unit and registers that unit's result onto the CDB. The registered CDB feeds the reorder buffer (tag-indexed speculative update) and the reservation stations (operand wakeup). A retire-bus flush cancels all pending grants and squashes the next broadcast.

## Interface
Parameters:
- N_REQ, 4, number of requesting execution units; index 0=int, 1=mult, 2=div, 3=ld_st
- TAG_W, 6, ROB tag width (64-entry ROB)
- DATA_W, 32, result data width

Ports:
- i_clk  input  1  clock; the only clock in the block
- i_rst_n  input  1  reset; synchronous, active-low
- i_flush  input  1  retire-bus flush (taken branch at ROB head)
- i_req_valid  input  N_REQ  per-unit result-ready request
- i_req_tag  input  N_REQ×TAG_W  per-unit ROB tag, packed array
- i_req_data  input  N_REQ×DATA_W  per-unit result or store data, packed array
- i_req_branch  input  N_REQ  result is a branch resolution
- i_req_taken  input  N_REQ  branch outcome; meaningful only with i_req_branch
- o_req_gnt  output  N_REQ  one-hot grant, combinational, same cycle as the request
- o_cdb_valid  output  1  CDB broadcast valid (registered)
- o_cdb_tag  output  TAG_W  broadcast ROB tag
- o_cdb_data  output  DATA_W  broadcast data
- o_cdb_branch  output  1  broadcast is a branch
- o_cdb_taken  output  1  branch taken

## Operation
- Requester handshake: a unit holds i_req_valid and its payload stable until it sees o_req_gnt[i]=1 in the same cycle. It drops or changes the request on the following cycle. No withdrawal is permitted before the grant.
- Arbitration: rr_ptr (clog2(N_REQ) bits) names the highest-priority index.
  - Search order is rr_ptr, rr_ptr+1, … mod N_REQ.
  - The first index with i_req_valid=1 wins.
- Pointer update: on any grant, rr_ptr <= (winner+1) mod N_REQ, wrapping from N_REQ-1 to 0. With no grant, rr_ptr holds.
- Grant gating: o_req_gnt=0 whenever i_flush=1 or i_rst_n=0. Otherwise o_req_gnt is one-hot or zero; zero only if no request is valid.
- CDB register:
  - On a grant, the winner's tag, data, branch and taken are loaded and o_cdb_valid<=1.
  - With no grant, o_cdb_valid<=0. Tag, data, branch and taken hold their last values; consumers qualify them with valid.
- Flush: in the i_flush cycle no grant is issued, o_cdb_valid<=0 and rr_ptr holds. Squashed units rely on their own flush to drop requests. Any request still held after the flush is arbitrated normally.
- Starvation bound: a continuously asserted request is granted within N_REQ cycles, absent flush.
- Reset values: o_cdb_valid=0, o_cdb_tag=0, o_cdb_data=0, o_cdb_branch=0, o_cdb_taken=0, rr_ptr=0, o_req_gnt=0.

## Timing
- Grant latency: 0 cycles, combinational from i_req_valid, rr_ptr, i_flush and i_rst_n.
- Broadcast latency: 1 cycle. A grant in cycle n gives o_cdb_valid=1 in cycle n+1.
- Throughput: one broadcast per cycle, back-to-back, with no bubble between different winners.
- Simultaneous flush and request: flush wins, so no grant and the CDB is invalid next cycle.
- Reset asserted mid-stream: at the next edge all registers take their reset values and the in-flight grant is lost. Requesters are reset by the same i_rst_n.
- Flush arriving the cycle after a grant: the registered broadcast in that cycle is still driven. The ROB and RS flush in the same edge and discard it.

## Structure
- Shared utils package:
  - CDB_TAG_W and CDB_DATA_W constants
  - exec_unit_e enum (INT, MULT, DIV, LD_ST), used for request indexing
  - cdb_pkt_t struct (valid, tag, data, branch, taken), used internally for the output register
- One sub-module, rr_priority_pick (N parameter): input vector plus start pointer, output one-hot plus encoded index. It is a pure combinational rotate-priority-encode.
- Top level contains rr_ptr, the grant gating, the payload mux and the CDB register.

## Test plan
- Reset: hold i_rst_n=0 for 3 cycles with all requests high -> o_req_gnt=0 and all CDB outputs 0. First release cycle: grant 0001 (rr_ptr=0).
- Rotation: all four units request continuously, tags 1/2/3/4 -> grants 0001, 0010, 0100, 1000, 0001; o_cdb_tag 1,2,3,4,1 one cycle later; o_cdb_valid stays 1.
- Pointer skip and wrap: rr_ptr=3, only units 1 and 3 request -> grant 1000 then 0010. After the unit-1 grant, rr_ptr=2.
- Flush collision: unit 2 requests tag 9 while i_flush=1 -> o_req_gnt=0 and o_cdb_valid=0 next cycle. The request is still held the next cycle -> granted, tag 9 on CDB the cycle after.
- Branch payload: unit 0 requests tag 5, branch=1, taken=1, data 0x0000_0040 -> next cycle o_cdb_valid=1, tag 5, data 0x40, branch 1, taken 1.
- Starvation: random requests for 10k cycles without flush -> every held request granted within 4 cycles (assertion); o_req_gnt always $onehot0.
